// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: combinational stall/flush/freeze in the detecting cycle, MEM_WAIT/FAULT FSM for slow memory.
// Optional saturating perf counters under HAZARD_PERF_CNT_EN; memory freeze holds every stage until mem_ready or timeout.
module pipeline_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  IF_ID_Rs,
   input  logic [2:0]  IF_ID_Rt,
   input  logic        IF_ID_uses_rt,
   input  logic        ID_EX_mem_read,
   input  logic [2:0]  ID_EX_write_reg,
   input  logic        branch_taken,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        PC_write,
   output logic        IF_ID_write,
   output logic        IF_ID_flush,
   output logic        ID_EX_flush,
   output logic        pipe_hold,
   output logic        mem_error,
   output logic [1:0]  ctrl_state,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_count
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_FAULT    = 2'b10
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_nxt;
   logic       load_use;
   logic [8:0] wait_inc;

   assign load_use = ID_EX_mem_read && (ID_EX_write_reg != 3'd0) &&
                     ((ID_EX_write_reg == IF_ID_Rs) ||
                      (IF_ID_uses_rt && (ID_EX_write_reg == IF_ID_Rt)));

   // wait_cnt counts frozen cycles including the first one seen in RUN
   assign wait_inc = {1'b0, wait_cnt} + 9'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_RUN;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      wait_nxt    = wait_cnt;
      PC_write    = 1'b1;
      IF_ID_write = 1'b1;
      IF_ID_flush = 1'b0;
      ID_EX_flush = 1'b0;
      pipe_hold   = 1'b0;

      case (state)
         ST_RUN: begin
            if (mem_req && !mem_ready) begin
               PC_write    = 1'b0;
               IF_ID_write = 1'b0;
               pipe_hold   = 1'b1;
               state_nxt   = ST_MEM_WAIT;
               wait_nxt    = 8'd1;
            end else if (branch_taken) begin
               IF_ID_flush = 1'b1;
               ID_EX_flush = 1'b1;
            end else if (load_use) begin
               PC_write    = 1'b0;
               IF_ID_write = 1'b0;
               ID_EX_flush = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (!mem_ready) begin
               PC_write    = 1'b0;
               IF_ID_write = 1'b0;
               pipe_hold   = 1'b1;
               if (wait_cnt != 8'hFF) begin
                  wait_nxt = wait_inc[7:0];
               end
               if (wait_inc >= 9'(MEM_TIMEOUT)) begin
                  state_nxt = ST_FAULT;
               end
            end else begin
               // released this cycle: the held instructions see normal RUN rules
               state_nxt = ST_RUN;
               wait_nxt  = 8'd0;
               if (branch_taken) begin
                  IF_ID_flush = 1'b1;
                  ID_EX_flush = 1'b1;
               end else if (load_use) begin
                  PC_write    = 1'b0;
                  IF_ID_write = 1'b0;
                  ID_EX_flush = 1'b1;
               end
            end
         end
         ST_FAULT: begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            pipe_hold   = 1'b1;
         end
         default: begin
            state_nxt = ST_RUN;
            wait_nxt  = 8'd0;
         end
      endcase

      if (reset) begin
         state_nxt   = ST_RUN;
         wait_nxt    = 8'd0;
         PC_write    = 1'b0;
         IF_ID_write = 1'b0;
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
         pipe_hold   = 1'b0;
      end
   end

   assign ctrl_state = reset ? ST_RUN : state;
   assign mem_error  = !reset && (state == ST_FAULT);

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_q, flush_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= 16'd0;
         flush_q <= 16'd0;
      end else begin
         if (!PC_write && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
         end
         if (IF_ID_flush && (flush_q != 16'hFFFF)) begin
            flush_q <= flush_q + 16'd1;
         end
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;
`else
   assign stall_cycles = 16'd0;
   assign flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed literal checks, then random traffic against a cycle-level reference model.
module tb_pipeline_hazard_ctrl;
   localparam int TO = 4;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [2:0]  IF_ID_Rs, IF_ID_Rt, ID_EX_write_reg;
   logic        IF_ID_uses_rt, ID_EX_mem_read, branch_taken, mem_req, mem_ready;
   logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_flush, pipe_hold, mem_error;
   logic [1:0]  ctrl_state;
   logic [15:0] stall_cycles, flush_count;

   int nchk  = 0;
   int nfail = 0;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_uses_rt(IF_ID_uses_rt),
      .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_write_reg(ID_EX_write_reg),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
      .ID_EX_flush(ID_EX_flush), .pipe_hold(pipe_hold), .mem_error(mem_error),
      .ctrl_state(ctrl_state), .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0=running, 1=waiting on memory, 2=faulted
   int m_mode = 0, m_waited = 0, m_stall = 0, m_flush = 0;

   always @(negedge clk) begin
      int  e_pc, e_ifw, e_iff, e_idf, e_hold, e_err, e_state;
      bit  frozen, lu;
      if (reset) begin
         e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1; e_hold = 0; e_err = 0; e_state = 0;
      end else begin
         e_state = m_mode;
         e_err   = (m_mode == 2) ? 1 : 0;
         frozen  = (m_mode == 2) || (m_mode == 0 && mem_req && !mem_ready) ||
                   (m_mode == 1 && !mem_ready);
         lu = ID_EX_mem_read && ID_EX_write_reg != 0 &&
              (ID_EX_write_reg == IF_ID_Rs || (IF_ID_uses_rt && ID_EX_write_reg == IF_ID_Rt));
         e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_hold = 0;
         if (frozen) begin
            e_pc = 0; e_ifw = 0; e_hold = 1;
         end else if (branch_taken) begin
            e_iff = 1; e_idf = 1;
         end else if (lu) begin
            e_pc = 0; e_ifw = 0; e_idf = 1;
         end
      end
      chk("PC_write",     16'(PC_write),     16'(e_pc));
      chk("IF_ID_write",  16'(IF_ID_write),  16'(e_ifw));
      chk("IF_ID_flush",  16'(IF_ID_flush),  16'(e_iff));
      chk("ID_EX_flush",  16'(ID_EX_flush),  16'(e_idf));
      chk("pipe_hold",    16'(pipe_hold),    16'(e_hold));
      chk("mem_error",    16'(mem_error),    16'(e_err));
      chk("ctrl_state",   16'(ctrl_state),   16'(e_state));
      chk("stall_cycles", stall_cycles, PERF ? 16'(m_stall) : 16'd0);
      chk("flush_count",  flush_count,  PERF ? 16'(m_flush) : 16'd0);

      if (reset) begin
         m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0;
      end else begin
         if (e_pc == 0 && m_stall < 65535) m_stall++;
         if (e_iff == 1 && m_flush < 65535) m_flush++;
         if (m_mode == 0 && mem_req && !mem_ready) begin
            m_mode = 1; m_waited = 1;
         end else if (m_mode == 1) begin
            if (!mem_ready) begin
               m_waited++;
               if (m_waited >= TO) m_mode = 2;
            end else begin
               m_mode = 0; m_waited = 0;
            end
         end
      end
   end

   task automatic step(input bit rst, input int rs, input int rt, input bit urt,
                       input bit mr, input int wr, input bit br, input bit mq, input bit rdy);
      @(posedge clk);
      #1;
      reset = rst; IF_ID_Rs = 3'(rs); IF_ID_Rt = 3'(rt); IF_ID_uses_rt = urt;
      ID_EX_mem_read = mr; ID_EX_write_reg = 3'(wr); branch_taken = br;
      mem_req = mq; mem_ready = rdy;
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      reset = 1'b1; IF_ID_Rs = 3'd0; IF_ID_Rt = 3'd0; IF_ID_uses_rt = 1'b0;
      ID_EX_mem_read = 1'b0; ID_EX_write_reg = 3'd0; branch_taken = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b1;

      step(1, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("lit_rst_pc", 16'(PC_write), 16'd0);
      chk("lit_rst_iff", 16'(IF_ID_flush), 16'd1);
      idle();
      chk("lit_run_pc", 16'(PC_write), 16'd1);
      chk("lit_run_stall0", stall_cycles, 16'd0);

      // load r3 then add r4,r3,r1
      step(0, 3, 5, 1, 1, 3, 0, 0, 1);
      chk("lit_lu_pc", 16'(PC_write), 16'd0);
      chk("lit_lu_ifw", 16'(IF_ID_write), 16'd0);
      chk("lit_lu_idf", 16'(ID_EX_flush), 16'd1);
      idle();
      chk("lit_bubble_pc", 16'(PC_write), 16'd1);
      chk("lit_lu_stall1", stall_cycles, PERF ? 16'd1 : 16'd0);

      step(0, 0, 0, 1, 1, 0, 0, 0, 1);
      chk("lit_r0_nostall", 16'(PC_write), 16'd1);
      step(0, 1, 2, 0, 1, 2, 0, 0, 1);
      chk("lit_rt_unused", 16'(PC_write), 16'd1);
      step(0, 1, 2, 1, 1, 2, 0, 0, 1);
      chk("lit_rt_used", 16'(PC_write), 16'd0);
      idle();

      // branch with simultaneous load-use
      step(0, 3, 0, 0, 1, 3, 1, 0, 1);
      chk("lit_br_iff", 16'(IF_ID_flush), 16'd1);
      chk("lit_br_idf", 16'(ID_EX_flush), 16'd1);
      chk("lit_br_pc", 16'(PC_write), 16'd1);
      idle();
      chk("lit_br_flushcnt", flush_count, PERF ? 16'd1 : 16'd0);

      // 3 cycles waiting on memory then ready
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("lit_mw1_hold", 16'(pipe_hold), 16'd1);
      chk("lit_mw1_state", 16'(ctrl_state), 16'd0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("lit_mw2_state", 16'(ctrl_state), 16'd1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      chk("lit_mw3_hold", 16'(pipe_hold), 16'd1);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1);
      chk("lit_mw4_hold", 16'(pipe_hold), 16'd0);
      chk("lit_mw4_state", 16'(ctrl_state), 16'd1);
      idle();
      chk("lit_mw5_state", 16'(ctrl_state), 16'd0);

      // branch held through a 2-cycle freeze
      step(0, 0, 0, 0, 0, 0, 1, 1, 0);
      chk("lit_fzbr1_iff", 16'(IF_ID_flush), 16'd0);
      step(0, 0, 0, 0, 0, 0, 1, 1, 0);
      chk("lit_fzbr2_iff", 16'(IF_ID_flush), 16'd0);
      step(0, 0, 0, 0, 0, 0, 1, 1, 1);
      chk("lit_fzbr3_iff", 16'(IF_ID_flush), 16'd1);
      chk("lit_fzbr3_hold", 16'(pipe_hold), 16'd0);
      idle();

      // timeout into FAULT, sticky until reset
      for (int i = 0; i < TO; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle();
      chk("lit_fault_state", 16'(ctrl_state), 16'd2);
      chk("lit_fault_err", 16'(mem_error), 16'd1);
      idle();
      chk("lit_fault_sticky", 16'(mem_error), 16'd1);
      chk("lit_fault_pc", 16'(PC_write), 16'd0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1);
      idle();
      chk("lit_postrst_err", 16'(mem_error), 16'd0);
      chk("lit_postrst_state", 16'(ctrl_state), 16'd0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         step($urandom_range(0, 99) < 2, $urandom_range(0, 7), $urandom_range(0, 7),
              1'($urandom), $urandom_range(0, 99) < 50, $urandom_range(0, 7),
              $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 30,
              $urandom_range(0, 99) < 70);
      end

      if (PERF) begin
         step(1, 0, 0, 0, 0, 0, 0, 0, 1);
         step(0, 0, 0, 0, 0, 0, 0, 1, 0);
         repeat (65600) @(posedge clk);
         @(negedge clk);
         #1;
         chk("lit_stall_sat", stall_cycles, 16'hFFFF);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15 (range 1..255): maximum cycles to wait for mem_ready before a fault.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock, sole clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 IF_ID_Rs  in  3  Rs of the instruction in ID.
REQ-006 IF_ID_Rt  in  3  Rt of the instruction in ID.
REQ-007 IF_ID_uses_rt  in  1  the ID instruction reads Rt.
REQ-008 ID_EX_mem_read  in  1  the EX instruction is a load.
REQ-009 ID_EX_write_reg  in  3  destination register of the EX instruction.
REQ-010 branch_taken  in  1  a taken branch or jump is resolved in EX.
REQ-011 mem_req  in  1  the MEM instruction accesses data memory.
REQ-012 mem_ready  in  1  data memory completes the access this cycle.
REQ-013 PC_write  out  1  PC update enable.
REQ-014 IF_ID_write  out  1  IF/ID register enable.
REQ-015 IF_ID_flush  out  1  zero IF/ID (bubble) at the next edge.
REQ-016 ID_EX_flush  out  1  zero ID/EX control (bubble) at the next edge.
REQ-017 pipe_hold  out  1  freeze the ID/EX, EX/MEM and MEM/WB registers.
REQ-018 mem_error  out  1  sticky memory-timeout fault.
REQ-019 ctrl_state  out  2  FSM state: 00=RUN, 01=MEM_WAIT, 10=FAULT.
REQ-020 stall_cycles  out  16  performance counter (see Configuration).
REQ-021 flush_count  out  16  performance counter (see Configuration).

Function
REQ-022 Outputs SHALL be combinational from the FSM state and current inputs, so a hazard is acted on in the cycle it is detected.
REQ-023 load_use SHALL be: ID_EX_mem_read && ID_EX_write_reg!=0 && (ID_EX_write_reg==IF_ID_Rs || (IF_ID_uses_rt && ID_EX_write_reg==IF_ID_Rt)).
REQ-024 Default in RUN with no event: PC_write=1, IF_ID_write=1, flushes=0, pipe_hold=0.
REQ-025 On load_use in RUN: PC_write=0, IF_ID_write=0, ID_EX_flush=1 for exactly that cycle; the bubble clears the condition on the next cycle.
REQ-026 On branch_taken in RUN: IF_ID_flush=1 and ID_EX_flush=1, PC_write=1; branch_taken SHALL suppress load_use stalling because the ID instruction is squashed.
REQ-027 In RUN, mem_req && !mem_ready: freeze the pipeline (PC_write=0, IF_ID_write=0, pipe_hold=1, no flush), go to MEM_WAIT, load wait_cnt=1.
REQ-028 In RUN, mem_req && mem_ready: no freeze; REQ-024..026 apply.
REQ-029 In MEM_WAIT, !mem_ready: hold the freeze; increment wait_cnt; when wait_cnt==MEM_TIMEOUT go to FAULT.
REQ-030 In MEM_WAIT, mem_ready: release in the same cycle and apply RUN rules to the current inputs, including a branch_taken held during the freeze; return to RUN.
REQ-031 Priority SHALL be: freeze > branch flush > load-use stall.
REQ-032 FAULT: full freeze, mem_error=1; leave only by reset.
REQ-033 wait_cnt is an internal 8-bit counter that SHALL NOT wrap.

Reset
REQ-034 During reset: state=RUN, wait_cnt=0, mem_error=0, counters=0, PC_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_flush=1, pipe_hold=0.
REQ-035 Reset in any state, including mid-MEM_WAIT or FAULT, SHALL take effect at the next edge and discard all pending waits.

Configuration
REQ-036 Macro HAZARD_PERF_CNT_EN defined: stall_cycles SHALL increment on every cycle where PC_write=0 outside reset; flush_count SHALL increment on every branch flush; both SHALL saturate at 16'hFFFF.
REQ-037 Macro HAZARD_PERF_CNT_EN undefined: the counters SHALL not be built, and stall_cycles and flush_count SHALL be tied to 0.

Verification
REQ-038 Load r3, then add r4,r3,r1 (Rs=3) -> exactly one cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1; stall_cycles=1.
REQ-039 Load r0, then use of r0 -> no stall; IF_ID_uses_rt=0 with Rt match only -> no stall.
REQ-040 branch_taken together with load_use -> IF_ID_flush=1, ID_EX_flush=1, PC_write=1; flush_count=1.
REQ-041 mem_req with mem_ready low for 3 cycles, then high -> pipe_hold=1 for 3 cycles, release on the 4th, ctrl_state 01 then 00.
REQ-042 MEM_TIMEOUT=4 and mem_ready never asserted -> FAULT after 4 wait cycles, mem_error=1 persists; reset -> RUN with mem_error=0.
REQ-043 branch_taken held during a 2-cycle freeze -> flush asserted only on the mem_ready cycle; counters saturate at FFFF after forced long stall, with the macro defined.
